// File: rtl/data_bus_controller.sv
// -----------------------------------------------------------------------------
// data_bus_controller
//
// CPU-side bus interface for an interrupt controller. It registers the CPU
// strobes once, detects edges on the registered copies, captures command
// writes, serves status-register reads through a snapshot latch, and runs the
// interrupt-acknowledge sequence that places the vector (8086 two-pulse mode)
// or a CALL opcode plus routine address (8080 three-pulse mode) on the bus.
//
// Ports
//   clk, reset        sole clock; synchronous active-high reset
//   DATABUS           bidirectional CPU data bus, high-Z unless bus_drive is 1
//   CS_N/RD_N/WR_N    active-low chip select, read and write strobes
//   A0                address bit, captured with each write
//   INTA_N            active-low interrupt-acknowledge strobe (ignores CS_N)
//   mode_8086         1 = two-pulse acknowledge, 0 = three-pulse 8080 style
//   read_select       chooses which status register a CPU read returns
//   status_regs       packed status registers, index 0 in the LSBs
//   vector_address    vector returned in 8086 mode
//   call_address      routine address returned in 8080 mode
//   command_word      last written data, write_a0 is A0 captured with it
//   write_strobe      one-cycle pulse per completed write
//   inta_first        one-cycle pulse on the first acknowledge falling edge
//   ack_done          one-cycle pulse when the acknowledge sequence ends
//   bus_drive         current DATABUS drive enable
// -----------------------------------------------------------------------------
module data_bus_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SOURCES = 4,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  inout  wire  [DATA_WIDTH-1:0]             DATABUS,
  input  logic                              CS_N,
  input  logic                              RD_N,
  input  logic                              WR_N,
  input  logic                              A0,
  input  logic                              INTA_N,
  input  logic                              mode_8086,
  input  logic [SEL_WIDTH-1:0]              read_select,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] status_regs,
  input  logic [DATA_WIDTH-1:0]             vector_address,
  input  logic [15:0]                       call_address,
  output logic [DATA_WIDTH-1:0]             command_word,
  output logic                              write_a0,
  output logic                              write_strobe,
  output logic                              inta_first,
  output logic                              ack_done,
  output logic                              bus_drive
);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2,
    ACK3
  } ack_state_t;

  ack_state_t state_q, state_d;

  // Registered strobe samples and their previous values for edge detection
  logic cs_n_q, cs_n_d;
  logic rd_n_q, rd_n_d;
  logic wr_n_q, wr_n_d;
  logic inta_n_q, inta_n_d;
  logic rd_n_prev_q, rd_n_prev_d;
  logic wr_n_prev_q, wr_n_prev_d;
  logic inta_n_prev_q, inta_n_prev_d;

  // Bus data and A0 are registered alongside the strobes so a write captures
  // the value that was present when the rising WR_N edge was sampled.
  logic a0_q, a0_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [DATA_WIDTH-1:0] command_word_q, command_word_d;
  logic                  write_a0_q, write_a0_d;
  logic                  write_strobe_q, write_strobe_d;
  logic                  inta_first_q, inta_first_d;
  logic                  ack_done_q, ack_done_d;
  logic                  bus_drive_q, bus_drive_d;
  logic [DATA_WIDTH-1:0] bus_data_q, bus_data_d;
  logic [DATA_WIDTH-1:0] read_latch_q, read_latch_d;
  logic                  read_active_q, read_active_d;
  logic                  conflict_q, conflict_d;
  logic                  mode_q, mode_d;

  logic                  rd_fall, wr_rise, inta_fall, inta_rise;
  logic                  conflict_now, cpu_blocked;
  logic                  ack_drive;
  logic [DATA_WIDTH-1:0] ack_data;
  logic [DATA_WIDTH-1:0] sel_value;

  assign rd_fall   = rd_n_prev_q & ~rd_n_q;
  assign wr_rise   = ~wr_n_prev_q & wr_n_q;
  assign inta_fall = inta_n_prev_q & ~inta_n_q;
  assign inta_rise = ~inta_n_prev_q & inta_n_q;

  // A simultaneous read and write is illegal; once seen, the CPU port stays
  // blocked until both strobes have returned high.
  assign conflict_now = ~cs_n_q & ~rd_n_q & ~wr_n_q;
  assign cpu_blocked  = conflict_now | conflict_q;

  // Status register mux; out-of-range selects return zero
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (read_select == SEL_WIDTH'(i)) begin
        sel_value = status_regs[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Strobe sampling, write capture, read snapshot and the acknowledge FSM
  always_comb begin
    cs_n_d         = CS_N;
    rd_n_d         = RD_N;
    wr_n_d         = WR_N;
    inta_n_d       = INTA_N;
    a0_d           = A0;
    data_d         = DATABUS;
    rd_n_prev_d    = rd_n_q;
    wr_n_prev_d    = wr_n_q;
    inta_n_prev_d  = inta_n_q;
    state_d        = state_q;
    mode_d         = mode_q;
    command_word_d = command_word_q;
    write_a0_d     = write_a0_q;
    write_strobe_d = 1'b0;
    inta_first_d   = 1'b0;
    ack_done_d     = 1'b0;
    read_latch_d   = read_latch_q;
    read_active_d  = read_active_q;
    bus_drive_d    = 1'b0;
    bus_data_d     = bus_data_q;
    ack_drive      = 1'b0;
    ack_data       = '0;

    conflict_d = conflict_now | (conflict_q & ~(rd_n_q & wr_n_q));

    if (wr_rise && !cs_n_q && !cpu_blocked) begin
      command_word_d = data_q;
      write_a0_d     = a0_q;
      write_strobe_d = 1'b1;
    end

    // A read ends when either strobe is sampled high; the snapshot is only
    // taken on the falling RD_N edge so it holds for the whole read.
    if (rd_n_q || cs_n_q || cpu_blocked) begin
      read_active_d = 1'b0;
    end
    if (rd_fall && !cs_n_q && !cpu_blocked) begin
      read_active_d = 1'b1;
      read_latch_d  = sel_value;
    end
    // Acknowledge has priority and aborts any read in progress
    if (inta_fall) begin
      read_active_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d      = ACK1;
          mode_d       = mode_8086;
          inta_first_d = 1'b1;
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (mode_q) begin
          if (inta_rise) begin
            state_d    = IDLE;
            ack_done_d = 1'b1;
          end
        end else if (inta_fall) begin
          state_d = ACK3;
        end
      end
      ACK3: begin
        if (inta_rise) begin
          state_d    = IDLE;
          ack_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The acknowledge byte is driven only while INTA_N is low in a state
    // that returns data; 8086 mode leaves the bus idle during ACK1.
    if (!inta_n_q) begin
      case (state_d)
        ACK1: begin
          if (!mode_d) begin
            ack_drive     = 1'b1;
            ack_data[7:0] = 8'hCD;
          end
        end
        ACK2: begin
          ack_drive = 1'b1;
          if (mode_d) begin
            ack_data = vector_address;
          end else begin
            ack_data[7:0] = call_address[7:0];
          end
        end
        ACK3: begin
          ack_drive     = 1'b1;
          ack_data[7:0] = call_address[15:8];
        end
        default: ack_drive = 1'b0;
      endcase
    end

    if (ack_drive) begin
      bus_drive_d = 1'b1;
      bus_data_d  = ack_data;
    end else if (read_active_d) begin
      bus_drive_d = 1'b1;
      bus_data_d  = read_latch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cs_n_q         <= 1'b1;
      rd_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      inta_n_q       <= 1'b1;
      rd_n_prev_q    <= 1'b1;
      wr_n_prev_q    <= 1'b1;
      inta_n_prev_q  <= 1'b1;
      a0_q           <= 1'b0;
      data_q         <= '0;
      command_word_q <= '0;
      write_a0_q     <= 1'b0;
      write_strobe_q <= 1'b0;
      inta_first_q   <= 1'b0;
      ack_done_q     <= 1'b0;
      bus_drive_q    <= 1'b0;
      bus_data_q     <= '0;
      read_latch_q   <= '0;
      read_active_q  <= 1'b0;
      conflict_q     <= 1'b0;
      mode_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cs_n_q         <= cs_n_d;
      rd_n_q         <= rd_n_d;
      wr_n_q         <= wr_n_d;
      inta_n_q       <= inta_n_d;
      rd_n_prev_q    <= rd_n_prev_d;
      wr_n_prev_q    <= wr_n_prev_d;
      inta_n_prev_q  <= inta_n_prev_d;
      a0_q           <= a0_d;
      data_q         <= data_d;
      command_word_q <= command_word_d;
      write_a0_q     <= write_a0_d;
      write_strobe_q <= write_strobe_d;
      inta_first_q   <= inta_first_d;
      ack_done_q     <= ack_done_d;
      bus_drive_q    <= bus_drive_d;
      bus_data_q     <= bus_data_d;
      read_latch_q   <= read_latch_d;
      read_active_q  <= read_active_d;
      conflict_q     <= conflict_d;
      mode_q         <= mode_d;
    end
  end

  assign DATABUS      = bus_drive_q ? bus_data_q : 'z;
  assign command_word = command_word_q;
  assign write_a0     = write_a0_q;
  assign write_strobe = write_strobe_q;
  assign inta_first   = inta_first_q;
  assign ack_done     = ack_done_q;
  assign bus_drive    = bus_drive_q;

endmodule

// File: tb/tb_data_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_data_bus_controller
//
// Stimulus tasks issue CPU writes, reads, illegal read/write overlaps and
// interrupt-acknowledge sequences. Each one pushes the responses it expects
// (write captures, driven bus bytes, inta_first and ack_done pulses) into
// queues; an independent monitor pops and compares whenever the DUT presents
// one of those outputs.
// -----------------------------------------------------------------------------
module tb_data_bus_controller;

   localparam int DW  = 8;
   localparam int NS  = 4;
   localparam int SW  = 2;

   logic          clk;
   logic          reset;
   wire  [DW-1:0] DATABUS;
   logic          CS_N, RD_N, WR_N, A0, INTA_N, mode_8086;
   logic [SW-1:0] read_select;
   logic [NS*DW-1:0] status_regs;
   logic [DW-1:0] vector_address;
   logic [15:0]   call_address;
   logic [DW-1:0] command_word;
   logic          write_a0, write_strobe, inta_first, ack_done, bus_drive;

   logic          tbBusEn;
   logic [DW-1:0] tbBusData;

   int checks = 0;
   int errors = 0;

   // Expected responses, filled by the stimulus and drained by the monitor
   logic [DW:0]   writeQ[$];
   logic [DW-1:0] busQ[$];
   int            pendFirst = 0;
   int            pendAck   = 0;
   logic [DW:0]   lastCmd   = '0;

   assign DATABUS = tbBusEn ? tbBusData : 'z;

   data_bus_controller #(
      .DATA_WIDTH (DW),
      .NUM_SOURCES(NS),
      .SEL_WIDTH  (SW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .DATABUS       (DATABUS),
      .CS_N          (CS_N),
      .RD_N          (RD_N),
      .WR_N          (WR_N),
      .A0            (A0),
      .INTA_N        (INTA_N),
      .mode_8086     (mode_8086),
      .read_select   (read_select),
      .status_regs   (status_regs),
      .vector_address(vector_address),
      .call_address  (call_address),
      .command_word  (command_word),
      .write_a0      (write_a0),
      .write_strobe  (write_strobe),
      .inta_first    (inta_first),
      .ack_done      (ack_done),
      .bus_drive     (bus_drive)
   );

   // Free-running clock, 10 ns period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every DUT pulse or new bus-drive episode must match the next
   // queued expectation, and every driven cycle must carry that value.
   logic          prevDrive = 1'b0;
   logic          haveExp   = 1'b0;
   logic [DW-1:0] curExp    = '0;

   always @(negedge clk) begin
      if (write_strobe) begin
         if (writeQ.size() == 0) begin
            checkOutput("unexpected_write_strobe", 32'd1, 32'd0);
         end else begin
            checkOutput("write_capture", 32'({write_a0, command_word}),
                        32'(writeQ.pop_front()));
         end
      end
      if (inta_first) begin
         checkOutput("unexpected_inta_first", 32'(pendFirst == 0), 32'd0);
         if (pendFirst > 0) pendFirst--;
      end
      if (bus_drive && !prevDrive) begin
         if (busQ.size() == 0) begin
            checkOutput("unexpected_bus_drive", 32'd1, 32'd0);
            haveExp = 1'b0;
         end else begin
            curExp  = busQ.pop_front();
            haveExp = 1'b1;
         end
      end
      if (bus_drive && haveExp) begin
         checkOutput("bus_value", 32'(DATABUS), 32'(curExp));
      end
      if (!bus_drive) haveExp = 1'b0;
      if (ack_done) begin
         checkOutput("unexpected_ack_done", 32'(pendAck == 0), 32'd0);
         if (pendAck > 0) pendAck--;
      end
      prevDrive = bus_drive;
   end

   task automatic doWrite(input logic [DW-1:0] data, input logic a0);
      tbBusData = data;
      tbBusEn   = 1'b1;
      A0        = a0;
      CS_N      = 1'b0;
      tick(1);
      WR_N = 1'b0;
      tick(2);
      writeQ.push_back({a0, data});
      lastCmd = {a0, data};
      WR_N = 1'b1;
      tick(3);
      checkOutput("write_command_word", 32'(command_word), 32'(data));
      checkOutput("write_a0", 32'(write_a0), 32'(a0));
      tbBusEn = 1'b0;
      CS_N    = 1'b1;
      A0      = 1'($urandom);
      tick(1);
   endtask

   task automatic doRead(input int sel, input logic [DW-1:0] val);
      status_regs              = $urandom;
      status_regs[sel*DW +: DW] = val;
      read_select              = SW'(sel);
      CS_N = 1'b0;
      tick(1);
      busQ.push_back(val);
      RD_N = 1'b0;
      tick(3);
      checkOutput("read_drive_on", 32'(bus_drive), 32'd1);
      // Sources and selection change under an active read
      status_regs = ~status_regs;
      read_select = SW'($urandom);
      tick(3);
      checkOutput("read_hold_value", 32'(DATABUS), 32'(val));
      RD_N = 1'b1;
      tick(2);
      checkOutput("read_release", 32'(bus_drive), 32'd0);
      CS_N = 1'b1;
      tick(1);
   endtask

   // One full acknowledge: expected bytes come from the mode chosen at the
   // first pulse, even if mode_8086 flips afterwards.
   task automatic doAck(input logic mode, input logic [DW-1:0] vec,
                        input logic [15:0] call, input logic flipMode);
      logic [DW-1:0] vals[3];
      int            n;
      mode_8086      = mode;
      vector_address = vec;
      call_address   = call;
      n       = mode ? 2 : 3;
      vals[0] = 8'hCD;
      vals[1] = mode ? vec : call[7:0];
      vals[2] = call[15:8];
      pendFirst++;
      for (int p = 0; p < n; p++) begin
         if (!(mode && p == 0)) busQ.push_back(vals[p]);
         if (p == n - 1) pendAck++;
         INTA_N = 1'b0;
         tick(3);
         checkOutput($sformatf("ack_drive_pulse%0d", p), 32'(bus_drive),
                     32'(!(mode && p == 0)));
         INTA_N = 1'b1;
         tick(3);
         if (p == 0 && flipMode) mode_8086 = ~mode;
      end
      tick(1);
   endtask

   // Read and write strobes low together; nothing may be captured or driven
   task automatic doConflict(input int order);
      status_regs = $urandom;
      tbBusData   = DW'($urandom);
      tbBusEn     = 1'b1;
      CS_N = 1'b0;
      tick(1);
      RD_N = 1'b0;
      WR_N = 1'b0;
      tick(3);
      checkOutput("conflict_no_drive", 32'(bus_drive), 32'd0);
      case (order)
         0: begin WR_N = 1'b1; tick(2); RD_N = 1'b1; end
         1: begin RD_N = 1'b1; tick(2); WR_N = 1'b1; end
         default: begin RD_N = 1'b1; WR_N = 1'b1; end
      endcase
      tick(4);
      checkOutput("conflict_no_latch", 32'({write_a0, command_word}), 32'(lastCmd));
      tbBusEn = 1'b0;
      CS_N    = 1'b1;
      tick(1);
   endtask

   // An 8086 acknowledge arriving during a read aborts it and frees the bus
   task automatic doReadAbort(input int sel, input logic [DW-1:0] val,
                              input logic [DW-1:0] vec);
      status_regs              = $urandom;
      status_regs[sel*DW +: DW] = val;
      read_select              = SW'(sel);
      mode_8086                = 1'b1;
      vector_address           = vec;
      CS_N = 1'b0;
      tick(1);
      busQ.push_back(val);
      RD_N = 1'b0;
      tick(3);
      pendFirst++;
      INTA_N = 1'b0;
      tick(2);
      checkOutput("abort_release", 32'(bus_drive), 32'd0);
      tick(1);
      INTA_N = 1'b1;
      tick(3);
      RD_N = 1'b1;
      CS_N = 1'b1;
      tick(2);
      busQ.push_back(vec);
      pendAck++;
      INTA_N = 1'b0;
      tick(3);
      INTA_N = 1'b1;
      tick(4);
   endtask

   // Reset lands while ACK2 is driving the vector
   task automatic doResetInAck2(input logic [DW-1:0] vec);
      mode_8086      = 1'b1;
      vector_address = vec;
      pendFirst++;
      INTA_N = 1'b0;
      tick(3);
      INTA_N = 1'b1;
      tick(3);
      busQ.push_back(vec);
      INTA_N = 1'b0;
      tick(3);
      reset = 1'b1;
      tick(1);
      checkOutput("reset_ack2_release", 32'(bus_drive), 32'd0);
      INTA_N = 1'b1;
      tick(2);
      reset = 1'b0;
      lastCmd = '0;
      tick(3);
      checkOutput("reset_ack2_no_ack_done", 32'(pendAck), 32'd0);
      doAck(1'b1, vec, 16'h0000, 1'b0);
   endtask

   task automatic applyStimulus(input int kind);
      case (kind)
         0: doWrite(DW'($urandom), 1'($urandom));
         1: doRead($urandom_range(0, NS - 1), DW'($urandom));
         2: doAck(1'($urandom), DW'($urandom), 16'($urandom), 1'($urandom));
         3: doConflict($urandom_range(0, 2));
         default: doReadAbort($urandom_range(0, NS - 1), DW'($urandom),
                              DW'($urandom));
      endcase
   endtask

   initial begin
      reset          = 1'b1;
      CS_N           = 1'b1;
      RD_N           = 1'b1;
      WR_N           = 1'b1;
      A0             = 1'b0;
      INTA_N         = 1'b1;
      mode_8086      = 1'b0;
      read_select    = '0;
      status_regs    = '0;
      vector_address = '0;
      call_address   = '0;
      tbBusEn        = 1'b0;
      tbBusData      = '0;
      tick(3);
      checkOutput("reset_command_word", 32'(command_word), 32'd0);
      checkOutput("reset_write_a0", 32'(write_a0), 32'd0);
      checkOutput("reset_write_strobe", 32'(write_strobe), 32'd0);
      checkOutput("reset_inta_first", 32'(inta_first), 32'd0);
      checkOutput("reset_ack_done", 32'(ack_done), 32'd0);
      checkOutput("reset_bus_drive", 32'(bus_drive), 32'd0);
      reset = 1'b0;
      tick(2);

      $display("[TB] directed cases");
      doWrite(8'h13, 1'b0);
      doRead(1, 8'hA5);
      doAck(1'b1, 8'h48, 16'h0000, 1'b0);
      doAck(1'b0, 8'h00, 16'h1234, 1'b0);
      doAck(1'b1, 8'h5A, 16'hBEEF, 1'b1);
      doAck(1'b0, 8'h77, 16'hC3E1, 1'b1);
      doConflict(0);
      doConflict(1);
      doConflict(2);
      doReadAbort(2, 8'h3C, 8'h91);
      doResetInAck2(8'h66);

      $display("[TB] randomized cases");
      for (int i = 0; i < 40; i++) begin
         applyStimulus($urandom_range(0, 4));
      end
      tick(10);

      checkOutput("leftover_writes", 32'(writeQ.size()), 32'd0);
      checkOutput("leftover_bus_bytes", 32'(busQ.size()), 32'd0);
      checkOutput("leftover_inta_first", 32'(pendFirst), 32'd0);
      checkOutput("leftover_ack_done", 32'(pendAck), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
